// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle shared by the control unit and the unified
// instruction/data memory.
//   mem_req : request a memory access (held until mem_ack)
//   mem_we  : 1 = write, 0 = read, qualifies mem_req
//   iord    : 0 = address from PC, 1 = address from ALU_out register
//   mem_ack : memory completed the current request this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared memory with a req/ack handshake,
// drives datapath enables and mux selects, and traps on illegal opcodes or
// memory timeouts.
//
// Ports:
//   CLK, rst_n          clock, synchronous active-low reset
//   op_code, funct      instruction fields from the IR
//   take_branch         branch condition, used in BRANCH
//   mem (master)        mem_req / mem_we / iord out, mem_ack in
//   ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, pc_to_reg,
//   alu_src_a, alu_src_b, alu_op   datapath controls
//   state               current state (debug)
//   instr_done          pulse on the last cycle of each retired instruction
//   trap, trap_cause    sticky trap flag and reason
//   cycle_cnt, instr_cnt  performance counters
//
// Optional feature: define MULTICYCLE_PERF_CNT_EN to build the performance
// counters; otherwise cycle_cnt/instr_cnt are tied to zero.
module multicycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op_code,
  input  logic [OP_W-1:0]     funct,
  input  logic                take_branch,
  multicycle_ctrl_if.master   mem,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic                mem_to_reg,
  output logic                pc_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_TRAP = 4'd11
  } state_t;

  typedef struct packed {
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               reg_we;
    logic [1:0]         reg_dst;
    logic               mem_to_reg;
    logic               pc_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               done;
  } ctl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'b001000);

  // Counter only has to reach WAIT_MAX-1: the WAIT_MAX-th unacked cycle traps.
  localparam int             WC_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam bit             TO_EN = (WAIT_MAX > 0);
  localparam logic [WC_W-1:0] WLIM = TO_EN ? WC_W'(WAIT_MAX - 1) : '0;

  // jump kind latched in DECODE: 0 = j, 1 = jal, 2 = jr
  state_t          st, nxt;
  ctl_t            ctl;
  logic            rflag, nxt_rf, is_sw, nxt_sw;
  logic [1:0]      jk, nxt_jk, cause_q, nxt_cause;
  logic [WC_W-1:0] wait_cnt;
  logic            trap_q, to_hit;

  // Moore decode; evaluated on the next state so the outputs come from flops.
  function automatic ctl_t decode(state_t s, logic rf, logic [1:0] k);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'd1; end
      S_DECODE:   c.alu_src_b = 2'd3;
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_W'(2); end
      S_EXEC_I,
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEM_WR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = 1'b1; end
      S_WB_MEM:   begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      S_WB_ALU:   begin c.reg_we = 1'b1; c.reg_dst = {1'b0, rf}; c.done = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_op = ALUOP_W'(1); c.pc_src = 2'd1; c.done = 1'b1;
      end
      S_JUMP:     begin
        c.pc_we = 1'b1; c.done = 1'b1;
        c.pc_src = (k == 2'd2) ? 2'd3 : 2'd2;
        if (k == 2'd1) begin c.reg_we = 1'b1; c.reg_dst = 2'd2; c.pc_to_reg = 1'b1; end
      end
      default: ;
    endcase
    return c;
  endfunction

  assign to_hit = TO_EN && !mem.mem_ack && (wait_cnt == WLIM);

  always_comb begin
    nxt       = st;
    nxt_rf    = rflag;
    nxt_sw    = is_sw;
    nxt_jk    = jk;
    nxt_cause = 2'd0;
    case (st)
      S_FETCH:
        if (mem.mem_ack) nxt = S_DECODE;
        else if (to_hit) begin nxt = S_TRAP; nxt_cause = 2'd2; end
      S_DECODE:
        case (op_code)
          OP_RTYPE:
            if (funct == FN_JR) begin nxt = S_JUMP; nxt_jk = 2'd2; end
            else begin nxt = S_EXEC_R; nxt_rf = 1'b1; end
          OP_LW:   begin nxt = S_MEM_ADDR; nxt_sw = 1'b0; end
          OP_SW:   begin nxt = S_MEM_ADDR; nxt_sw = 1'b1; end
          OP_ADDI: begin nxt = S_EXEC_I; nxt_rf = 1'b0; end
          OP_BEQ:  nxt = S_BRANCH;
          OP_J:    begin nxt = S_JUMP; nxt_jk = 2'd0; end
          OP_JAL:  begin nxt = S_JUMP; nxt_jk = 2'd1; end
          default: begin nxt = S_TRAP; nxt_cause = 2'd1; end
        endcase
      S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:
        if (mem.mem_ack) nxt = S_WB_MEM;
        else if (to_hit) begin nxt = S_TRAP; nxt_cause = 2'd3; end
      S_MEM_WR:
        if (mem.mem_ack) nxt = S_FETCH;
        else if (to_hit) begin nxt = S_TRAP; nxt_cause = 2'd3; end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      st       <= S_FETCH;
      ctl      <= decode(S_FETCH, 1'b0, 2'd0);
      rflag    <= 1'b0;
      is_sw    <= 1'b0;
      jk       <= 2'd0;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'd0;
    end else begin
      st    <= nxt;
      ctl   <= decode(nxt, nxt_rf, nxt_jk);
      rflag <= nxt_rf;
      is_sw <= nxt_sw;
      jk    <= nxt_jk;
      // counts consecutive unacked cycles of one request; any move restarts it
      if (ctl.mem_req && !mem.mem_ack && nxt == st) wait_cnt <= wait_cnt + 1'b1;
      else                                          wait_cnt <= '0;
      if (nxt == S_TRAP && st != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= nxt_cause;
      end
    end
  end

  logic fetch_ack;
  assign fetch_ack   = (st == S_FETCH) && mem.mem_ack;

  assign mem.mem_req = ctl.mem_req;
  assign mem.mem_we  = ctl.mem_we;
  assign mem.iord    = ctl.iord;
  assign ir_we       = fetch_ack;
  assign pc_we       = ctl.pc_we | fetch_ack | ((st == S_BRANCH) && take_branch);
  assign pc_src      = ctl.pc_src;
  assign reg_we      = ctl.reg_we;
  assign reg_dst     = ctl.reg_dst;
  assign mem_to_reg  = ctl.mem_to_reg;
  assign pc_to_reg   = ctl.pc_to_reg;
  assign alu_src_a   = ctl.alu_src_a;
  assign alu_src_b   = ctl.alu_src_b;
  assign alu_op      = ctl.alu_op;
  assign state       = st;
  assign instr_done  = ctl.done | ((st == S_MEM_WR) && mem.mem_ack);
  assign trap        = trap_q;
  assign trap_cause  = cause_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (instr_done) ins_q <= ins_q + 1'b1;
    end
  end
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl. Each instruction is expanded by the
// bench into its expected per-cycle state trace from its class, ack delays
// and timeout limit; a single compare process checks all outputs every cycle.
module tb_multicycle_ctrl;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;
`ifdef MULTICYCLE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                 K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic       mem_to_reg, pc_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       done, trap;
    logic [1:0] cause;
  } obs_t;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic [5:0]       op_code, funct;
  logic             take_branch;
  logic             ir_we, pc_we, reg_we, mem_to_reg, pc_to_reg, alu_src_a;
  logic             instr_done, trap;
  logic [1:0]       pc_src, reg_dst, alu_src_b, trap_cause;
  logic [3:0]       alu_op, state;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(4), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .rst_n(rst_n), .op_code(op_code), .funct(funct),
    .take_branch(take_branch), .mem(mem_if.master),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  obs_t obs, exp_o;
  logic [CNT_W-1:0] exp_cc, exp_ic;
  bit   exp_vld = 1'b0;
  int   n_chk = 0, n_pass = 0, n_cyc = 0;
  int   m_cyc = 0, m_ins = 0, cur_kind = 0;
  bit   m_trap = 1'b0;
  logic [1:0] m_cause = 2'd0;

  always_comb begin
    obs            = '0;
    obs.st         = state;
    obs.mem_req    = mem_if.mem_req;
    obs.mem_we     = mem_if.mem_we;
    obs.iord       = mem_if.iord;
    obs.ir_we      = ir_we;
    obs.pc_we      = pc_we;
    obs.pc_src     = pc_src;
    obs.reg_we     = reg_we;
    obs.reg_dst    = reg_dst;
    obs.mem_to_reg = mem_to_reg;
    obs.pc_to_reg  = pc_to_reg;
    obs.alu_src_a  = alu_src_a;
    obs.alu_src_b  = alu_src_b;
    obs.alu_op     = alu_op;
    obs.done       = instr_done;
    obs.trap       = trap;
    obs.cause      = trap_cause;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
  endtask

  // Expected outputs of one cycle, from the state the instruction is in and
  // the handshake inputs of that cycle.
  function automatic obs_t spec_out(int st, bit ack, bit tbr);
    obs_t o;
    o = '0;
    o.st = 4'(st); o.trap = m_trap; o.cause = m_cause;
    case (st)
      0:  begin o.mem_req = 1; o.alu_src_b = 2'd1; o.ir_we = ack; o.pc_we = ack; end
      1:  o.alu_src_b = 2'd3;
      2:  begin o.alu_src_a = 1; o.alu_op = 4'd2; end
      3, 4: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      5:  begin o.mem_req = 1; o.iord = 1; end
      6:  begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; o.done = ack; end
      7:  begin o.reg_we = 1; o.mem_to_reg = 1; o.done = 1; end
      8:  begin o.reg_we = 1; o.reg_dst = (cur_kind == K_R) ? 2'd1 : 2'd0; o.done = 1; end
      9:  begin o.alu_src_a = 1; o.alu_op = 4'd1; o.pc_src = 2'd1; o.pc_we = tbr; o.done = 1; end
      10: begin
        o.pc_we = 1; o.done = 1;
        o.pc_src = (cur_kind == K_JR) ? 2'd3 : 2'd2;
        if (cur_kind == K_JAL) begin o.reg_we = 1; o.reg_dst = 2'd2; o.pc_to_reg = 1; end
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit valid_op(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000,
                      6'b000100, 6'b000010, 6'b000011};
  endfunction

  // one clock cycle in which the DUT is expected to be in state st
  task automatic cyc(input int st, input bit ack, input bit tbr);
    @(negedge CLK);
    rst_n = 1'b1;
    mem_if.mem_ack = ack;
    take_branch = tbr;
    exp_o  = spec_out(st, ack, tbr);
    exp_cc = PERF ? CNT_W'(m_cyc) : '0;
    exp_ic = PERF ? CNT_W'(m_ins) : '0;
    exp_vld = 1'b1;
    m_cyc++;
    if (exp_o.done) m_ins++;
    n_cyc++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    exp_vld = 1'b0;
    rst_n = 1'b0;
    mem_if.mem_ack = rb();
    take_branch = rb();
    m_trap = 1'b0; m_cause = 2'd0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic trap_tail(input logic [1:0] c);
    m_trap = 1'b1; m_cause = c;
    repeat (3) cyc(11, rb(), rb());
  endtask

  // fw/mw: unacked cycles before the fetch/data ack (>= WAIT_MAX means never)
  task automatic do_instr(input int k, input int fw, input int mw, input bit tbr,
                          output int n);
    int n0, ms;
    logic [5:0] op, fn;
    n0 = n_cyc;
    fn = 6'($urandom);
    op = 6'b000000;
    case (k)
      K_R:    if (fn == 6'b001000) fn = 6'b100000;
      K_JR:   fn = 6'b001000;
      K_ADDI: op = 6'b001000;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        op = 6'b111111;
        if (rb()) begin
          op = 6'($urandom);
          while (valid_op(op)) op = 6'($urandom);
        end
      end
    endcase
    op_code = op; funct = fn; cur_kind = k;
    if (fw >= WAIT_MAX) begin
      repeat (WAIT_MAX) cyc(0, 1'b0, rb());
      trap_tail(2'd2);
    end else begin
      repeat (fw) cyc(0, 1'b0, rb());
      cyc(0, 1'b1, rb());
      cyc(1, rb(), rb());
      case (k)
        K_R:    begin cyc(2, rb(), rb()); cyc(8, rb(), rb()); end
        K_ADDI: begin cyc(3, rb(), rb()); cyc(8, rb(), rb()); end
        K_LW, K_SW: begin
          cyc(4, rb(), rb());
          ms = (k == K_LW) ? 5 : 6;
          if (mw >= WAIT_MAX) begin
            repeat (WAIT_MAX) cyc(ms, 1'b0, rb());
            trap_tail(2'd3);
          end else begin
            repeat (mw) cyc(ms, 1'b0, rb());
            cyc(ms, 1'b1, rb());
            if (k == K_LW) cyc(7, rb(), rb());
          end
        end
        K_BEQ:  cyc(9, rb(), tbr);
        K_J, K_JAL, K_JR: cyc(10, rb(), rb());
        default: trap_tail(2'd1);
      endcase
    end
    n = n_cyc - n0;
  endtask

  always @(negedge CLK) begin
    #2;
    if (exp_vld) begin
      chk("outputs", 64'(obs), 64'(exp_o));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(exp_cc));
      chk("instr_cnt", 64'(instr_cnt), 64'(exp_ic));
    end
  end

  initial begin
    int n, k, fw, mw;
    rst_n = 1'b0; mem_if.mem_ack = 1'b0; take_branch = 1'b0;
    op_code = '0; funct = '0;
    repeat (2) @(negedge CLK);
    do_reset();

    do_instr(K_ADDI, 0, 0, 0, n);  chk("addi_cycles", 64'(n), 64'd4);
    do_instr(K_LW, 0, 3, 0, n);    chk("lw_cycles", 64'(n), 64'd8);
    do_instr(K_BEQ, 0, 0, 1, n);   chk("beq_t_cycles", 64'(n), 64'd3);
    do_instr(K_BEQ, 0, 0, 0, n);   chk("beq_nt_cycles", 64'(n), 64'd3);
    do_instr(K_JAL, 0, 0, 0, n);
    do_instr(K_SW, 2, 1, 0, n);    chk("sw_cycles", 64'(n), 64'd7);
    do_instr(K_ADDI, 14, 0, 0, n); chk("ack_at_limit", 64'(n), 64'd18);

    do_reset();
    repeat (3) do_instr(K_ADDI, 0, 0, 0, n);
    cyc(0, 1'b0, 1'b0);
    #3;
    chk("perf_cycles", 64'(cycle_cnt), PERF ? 64'd12 : 64'd0);
    chk("perf_instrs", 64'(instr_cnt), PERF ? 64'd3 : 64'd0);

    do_reset();
    do_instr(K_ILL, 0, 0, 0, n);
    #3; chk("ill_cause", 64'(trap_cause), 64'd1);
    do_reset();
    do_instr(K_ADDI, WAIT_MAX, 0, 0, n);
    #3; chk("fetch_to_cause", 64'(trap_cause), 64'd2);
    chk("fetch_to_state", 64'(state), 64'd11);
    do_reset();

    // reset in the middle of a lw abandons it
    cur_kind = K_LW; op_code = 6'b100011;
    cyc(0, 1'b1, 1'b0); cyc(1, 1'b0, 1'b0); cyc(4, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 8);
      fw = ($urandom_range(0, 24) == 0) ? WAIT_MAX : $urandom_range(0, 3);
      mw = ($urandom_range(0, 10) == 0) ? WAIT_MAX : $urandom_range(0, 4);
      do_instr(k, fw, mw, rb(), n);
      if (m_trap || $urandom_range(0, 30) == 0) do_reset();
    end

    @(negedge CLK);
    exp_vld = 1'b0;
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
